// File: rtl/nios_ocimem_pkg.sv
// Shared definitions for the Nios II debug-memory controller: jdo field layout,
// FSM state encoding and a byte-lane helper.
package nios_ocimem_pkg;

   localparam int unsigned JDO_W         = 38;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned JDO_ADDR_LSB  = 26;
   localparam int unsigned JDO_RD_FLAG   = 34;
   localparam int unsigned JDO_WDATA_LSB = 3;
   localparam int unsigned JDO_WDATA_MSB = 34;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_JRD  = 2'd1,
      ST_CRD  = 2'd2
   } ocimem_state_e;

   function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] be);
      lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/nios_system_nios2_group_5_ocimem_ram.sv
// Single-port debug RAM: byte-enable write, registered read that holds its
// value until the next read-enable cycle.
module nios_system_nios2_group_5_ocimem_ram
   import nios_ocimem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage array; deliberately not reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= (mem_q[addr_i] & ~lane_mask(be_i)) | (wdata_i & lane_mask(be_i));
      end
   end

   // Read register, updated only on read-enable cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= {DATA_W{1'b0}};
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/nios_system_nios2_group_5_ocimem_ctrl.sv
// Debug memory controller: decodes JTAG wrapper commands, arbitrates the debug
// RAM between debugger and CPU (Avalon-MM), and returns data on MonDReg.
module nios_system_nios2_group_5_ocimem_ctrl
   import nios_ocimem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_waitrequest,
   output logic [DATA_W-1:0] MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              jtag_busy
);

   ocimem_state_e     state_q, state_d;
   logic [ADDR_W-1:0] mon_areg_q, mon_areg_d;
   logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
   logic [DATA_W-1:0] avs_rdata_q, avs_rdata_d;
   logic              busy_q, busy_d;

   logic              cmd_wr_s, cmd_set_s, cmd_rdn_s, jtag_cmd_s, jtag_rd_s;
   logic              cpu_wr_gnt_s, cpu_rd_gnt_s, done_s;
   logic [ADDR_W-1:0] jdo_addr_s, jdo_addr_inc_s, areg_inc_s;
   logic              ram_we_s, ram_re_s;
   logic [3:0]        ram_be_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [DATA_W-1:0] ram_wdata_s, ram_rdata_s;
   logic              jdo_unused_s;

   assign jdo_addr_s     = jdo[JDO_ADDR_LSB +: ADDR_W];
   assign jdo_addr_inc_s = jdo_addr_s + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign areg_inc_s     = mon_areg_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign jdo_unused_s   = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};

   // Command decode with write > address-set > read-next priority, then CPU grant.
   always_comb begin
      cmd_wr_s     = take_action_ocimem_b;
      cmd_set_s    = take_action_ocimem_a & ~take_action_ocimem_b;
      cmd_rdn_s    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
      jtag_cmd_s   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
      jtag_rd_s    = (cmd_set_s & jdo[JDO_RD_FLAG]) | cmd_rdn_s;
      cpu_wr_gnt_s = ~jtag_cmd_s & avs_write;
      // A read already in its capture cycle must not be granted a second time.
      cpu_rd_gnt_s = ~jtag_cmd_s & avs_read & ~avs_write & (state_q != ST_CRD);
      done_s       = cpu_wr_gnt_s | (avs_read & (state_q == ST_CRD));
   end

   // RAM port steering: the debugger owns the port in any take-pulse cycle.
   always_comb begin
      ram_we_s    = cmd_wr_s | cpu_wr_gnt_s;
      ram_re_s    = jtag_rd_s | cpu_rd_gnt_s;
      ram_be_s    = avs_byteenable;
      ram_addr_s  = avs_address;
      ram_wdata_s = avs_writedata;
      if (jtag_cmd_s) begin
         ram_be_s    = 4'hF;
         ram_addr_s  = cmd_set_s ? jdo_addr_s : mon_areg_q;
         ram_wdata_s = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
      end else begin
         ram_be_s    = avs_byteenable;
         ram_addr_s  = avs_address;
         ram_wdata_s = avs_writedata;
      end
   end

   // FSM next state plus capture of held RAM data into MonDReg / avs_readdata.
   always_comb begin
      state_d     = ST_IDLE;
      mon_dreg_d  = mon_dreg_q;
      avs_rdata_d = avs_rdata_q;
      busy_d      = jtag_rd_s | (state_q == ST_JRD);
      if (jtag_rd_s) begin
         state_d = ST_JRD;
      end else if (cpu_rd_gnt_s) begin
         state_d = ST_CRD;
      end else begin
         state_d = ST_IDLE;
      end
      case (state_q)
         ST_IDLE: begin
            mon_dreg_d  = mon_dreg_q;
            avs_rdata_d = avs_rdata_q;
         end
         ST_JRD:  mon_dreg_d  = ram_rdata_s;
         ST_CRD:  avs_rdata_d = ram_rdata_s;
         default: state_d     = ST_IDLE;
      endcase
   end

   // Debugger address register; every debugger RAM access post-increments it.
   always_comb begin
      mon_areg_d = mon_areg_q;
      if (cmd_set_s) begin
         mon_areg_d = jdo[JDO_RD_FLAG] ? jdo_addr_inc_s : jdo_addr_s;
      end else if (cmd_wr_s | cmd_rdn_s) begin
         mon_areg_d = areg_inc_s;
      end else begin
         mon_areg_d = mon_areg_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         mon_areg_q  <= {ADDR_W{1'b0}};
         mon_dreg_q  <= {DATA_W{1'b0}};
         avs_rdata_q <= {DATA_W{1'b0}};
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mon_areg_q  <= mon_areg_d;
         mon_dreg_q  <= mon_dreg_d;
         avs_rdata_q <= avs_rdata_d;
         busy_q      <= busy_d;
      end
   end

   nios_system_nios2_group_5_ocimem_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .addr_i  (ram_addr_s),
      .we_i    (ram_we_s),
      .be_i    (ram_be_s),
      .wdata_i (ram_wdata_s),
      .re_i    (ram_re_s),
      .rdata_o (ram_rdata_s)
   );

   // CPU read data is presented straight from the RAM register in its capture cycle.
   assign avs_readdata    = (state_q == ST_CRD) ? ram_rdata_s : avs_rdata_q;
   assign avs_waitrequest = (avs_read | avs_write) & ~done_s;
   assign MonDReg         = mon_dreg_q;
   assign MonAReg         = mon_areg_q;
   assign jtag_busy       = busy_q;

endmodule

// File: tb/tb_nios_system_nios2_group_5_ocimem_ctrl.sv
// Randomized self-checking bench for the debug memory controller against an
// operation-level model (memory array, address and data registers).
module tb_nios_system_nios2_group_5_ocimem_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [7:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [31:0] mon_dreg;
   logic [7:0]  mon_areg;
   logic        jtag_busy;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [256];
   logic [7:0]  ref_areg;
   logic [31:0] ref_dreg;
   logic [31:0] rd_val;

   always #5 clk = ~clk;

   nios_system_nios2_group_5_ocimem_ctrl #(.ADDR_W(8)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_byteenable          (avs_byteenable),
      .avs_readdata            (avs_readdata),
      .avs_waitrequest         (avs_waitrequest),
      .MonDReg                 (mon_dreg),
      .MonAReg                 (mon_areg),
      .jtag_busy               (jtag_busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Debugger command semantics at transaction level.
   task automatic model_jtag(input logic a, input logic b, input logic n, input logic [37:0] j);
      if (b) begin
         ref_mem[ref_areg] = j[34:3];
         ref_areg = ref_areg + 8'd1;
      end else if (a) begin
         ref_areg = j[33:26];
         if (j[34]) begin
            ref_dreg = ref_mem[ref_areg];
            ref_areg = ref_areg + 8'd1;
         end
      end else if (n) begin
         ref_dreg = ref_mem[ref_areg];
         ref_areg = ref_areg + 8'd1;
      end
   endtask

   task automatic jtag_pulse(input logic a, input logic b, input logic n, input logic [37:0] j);
      logic exp_rd;
      exp_rd = !b && (a ? j[34] : n);
      @(negedge clk);
      jdo = j;
      take_action_ocimem_a = a;
      take_action_ocimem_b = b;
      take_no_action_ocimem_a = n;
      model_jtag(a, b, n, j);
      @(negedge clk);
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      check_val("busy_n1", {31'd0, jtag_busy}, {31'd0, exp_rd});
      check_val("mon_areg", {24'd0, mon_areg}, {24'd0, ref_areg});
      @(negedge clk);
      check_val("busy_n2", {31'd0, jtag_busy}, {31'd0, exp_rd});
      check_val("mon_dreg", mon_dreg, ref_dreg);
      @(negedge clk);
      check_val("busy_n3", {31'd0, jtag_busy}, 32'd0);
   endtask

   task automatic jtag_set(input logic [7:0] addr, input logic rd);
      jtag_pulse(1'b1, 1'b0, 1'b0, {3'b000, rd, addr, 26'd0});
   endtask

   task automatic jtag_write(input logic [31:0] d);
      jtag_pulse(1'b0, 1'b1, 1'b0, {3'b000, d, 3'b000});
   endtask

   task automatic jtag_rdn();
      jtag_pulse(1'b0, 1'b0, 1'b1, {6'($urandom), 32'($urandom)});
   endtask

   task automatic cpu_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
      int cyc;
      @(negedge clk);
      avs_address = addr; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
      #1;
      cyc = 1;
      while (avs_waitrequest && cyc < 10) begin
         @(negedge clk); #1; cyc++;
      end
      check_val("cpu_wr_wait", {31'd0, avs_waitrequest}, 32'd0);
      check_val("cpu_wr_cycles", cyc, 32'd1);
      for (int b = 0; b < 4; b++) begin
         if (be[b]) ref_mem[addr][8*b +: 8] = d[8*b +: 8];
      end
      @(posedge clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] addr, output logic [31:0] d);
      int cyc;
      @(negedge clk);
      avs_address = addr; avs_read = 1'b1;
      #1;
      cyc = 1;
      while (avs_waitrequest && cyc < 10) begin
         @(negedge clk); #1; cyc++;
      end
      check_val("cpu_rd_wait", {31'd0, avs_waitrequest}, 32'd0);
      check_val("cpu_rd_cycles", cyc, 32'd2);
      check_val("cpu_rd_data", avs_readdata, ref_mem[addr]);
      d = avs_readdata;
      @(posedge clk); #1;
      avs_read = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      jdo = 38'd0;
      take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
      avs_address = 8'd0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = 32'd0; avs_byteenable = 4'h0;
      ref_areg = 8'd0; ref_dreg = 32'd0;
      repeat (3) @(negedge clk);
      check_val("rst_dreg", mon_dreg, 32'd0);
      check_val("rst_areg", {24'd0, mon_areg}, 32'd0);
      check_val("rst_rdata", avs_readdata, 32'd0);
      check_val("rst_busy", {31'd0, jtag_busy}, 32'd0);
      check_val("rst_wait", {31'd0, avs_waitrequest}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 256; i++) cpu_write(8'(i), 32'd0, 4'hF);

      // Address-set without read.
      jtag_set(8'h10, 1'b0);
      check_val("set_areg", {24'd0, mon_areg}, 32'h10);
      check_val("set_dreg", mon_dreg, 32'd0);

      // Two writes, then read them back through the debugger.
      jtag_write(32'hDEADBEEF);
      jtag_write(32'h12345678);
      jtag_set(8'h10, 1'b1);
      check_val("rd_first", mon_dreg, 32'hDEADBEEF);
      jtag_rdn();
      check_val("rd_second", mon_dreg, 32'h12345678);
      check_val("rd_areg", {24'd0, mon_areg}, 32'h12);

      // Address wrap at 0xFF.
      jtag_set(8'hFF, 1'b0);
      jtag_write(32'hCAFEF00D);
      check_val("wrap_areg0", {24'd0, mon_areg}, 32'h00);
      jtag_rdn();
      check_val("wrap_areg1", {24'd0, mon_areg}, 32'h01);
      cpu_read(8'hFF, rd_val);
      check_val("wrap_ff", rd_val, 32'hCAFEF00D);

      // Byte-enable CPU write.
      cpu_write(8'h40, 32'hAABBCCDD, 4'b0101);
      cpu_read(8'h40, rd_val);
      check_val("be_merge", rd_val, 32'h00BB00DD);

      // CPU read colliding with a take-pulse.
      @(negedge clk);
      jdo = {3'b000, 1'b0, 8'h20, 26'd0};
      take_action_ocimem_a = 1'b1;
      avs_address = 8'h10; avs_read = 1'b1;
      model_jtag(1'b1, 1'b0, 1'b0, jdo);
      #1;
      check_val("coll_wait_p", {31'd0, avs_waitrequest}, 32'd1);
      @(negedge clk);
      take_action_ocimem_a = 1'b0;
      #1;
      check_val("coll_wait_g", {31'd0, avs_waitrequest}, 32'd1);
      @(negedge clk); #1;
      check_val("coll_wait_g1", {31'd0, avs_waitrequest}, 32'd0);
      check_val("coll_data", avs_readdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      avs_read = 1'b0;
      repeat (3) @(negedge clk);
      check_val("coll_areg", {24'd0, mon_areg}, 32'h20);

      // Coinciding pulses: write wins.
      jtag_pulse(1'b1, 1'b1, 1'b1, {6'($urandom), 32'($urandom)});
      cpu_read(8'h20, rd_val);

      // Reset during the MonDReg capture cycle.
      @(negedge clk);
      jdo = 38'd0;
      take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      take_no_action_ocimem_a = 1'b0;
      check_val("jrd_busy", {31'd0, jtag_busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_val("mid_rst_dreg", mon_dreg, 32'd0);
      check_val("mid_rst_areg", {24'd0, mon_areg}, 32'd0);
      check_val("mid_rst_busy", {31'd0, jtag_busy}, 32'd0);
      ref_areg = 8'd0; ref_dreg = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("post_rst_dreg", mon_dreg, 32'd0);
      jtag_set(8'h10, 1'b1);
      check_val("post_rst_data", mon_dreg, 32'hDEADBEEF);

      // Randomized mix of debugger and CPU operations.
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 4))
            0: jtag_set(8'($urandom), 1'($urandom));
            1: jtag_write($urandom);
            2: jtag_rdn();
            3: cpu_write(8'($urandom), $urandom, 4'($urandom));
            default: cpu_read(8'($urandom), rd_val);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
